pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Drives the write-enables and bubble/flush controls of the PC register and the FD, DX, XM and MW latches. Resolves three hazards: load-use, taken branch, and multi-cycle mult/div occupancy of execute. Runs a start/ready handshake with the multdiv unit, with a timeout, and keeps a saturating stall-cycle counter.

Parameters:
MD_TIMEOUT, 64, MD_WAIT cycles without md_ready before forced release (must be ≥2)
CNT_W, 16, width of stall_count

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  synchronous, active-low; sampled on the rising edge of clock
fd_rs  in  5  rs field of instruction in FD
fd_rt  in  5  rt field of instruction in FD
fd_uses_rs  in  1  FD instruction reads rs
fd_uses_rt  in  1  FD instruction reads rt
dx_is_load  in  1  DX instruction is lw
dx_rd  in  5  destination register of DX instruction
dx_is_multdiv  in  1  DX instruction is mul/div
branch_taken  in  1  branch/jump resolved taken in execute this cycle
md_ready  in  1  multdiv result valid (single-cycle pulse)
md_exception  in  1  multdiv error; qualified by md_ready
md_start  out  1  one-cycle start pulse to multdiv
md_busy  out  1  high in MD_WAIT
md_timeout  out  1  one-cycle pulse on forced release
pc_wren, fd_wren, dx_wren, xm_wren, mw_wren  out  1 each  latch enables
fd_flush, dx_flush, xm_flush  out  1 each  load nop (all zeros) into that latch on next edge
stall_count  out  CNT_W  cycles with pc_wren=0

Behaviour:
- States: IDLE, MD_WAIT. Registered: state, md_cycles (up to MD_TIMEOUT), stall_count. All other outputs are combinational from state and inputs.
- Reset (reset=0 at an edge): next state IDLE, md_cycles=0, stall_count=0. While reset=0, outputs are forced: all *_wren=1, all *_flush=0, md_start=md_busy=md_timeout=0. This applies mid-MD_WAIT as well; no md_start is reissued.
- Default (IDLE, no hazard): all wren=1, all flush=0.
- Priority in IDLE: multdiv > branch > load-use.
- IDLE with dx_is_multdiv=1:
  - md_start=1.
  - pc/fd/dx_wren=0; xm_flush=1 (bubble into XM); mw_wren=1 so older instructions drain.
  - Next state MD_WAIT; md_cycles=0.
- IDLE with branch_taken=1 (no multdiv):
  - fd_flush=1, dx_flush=1; all wren=1.
  - A simultaneous load-use is ignored because the dependent instruction is squashed.
- IDLE load-use:
  - Condition: dx_is_load & dx_rd≠0 & ((fd_uses_rs & fd_rs==dx_rd) | (fd_uses_rt & fd_rt==dx_rd)).
  - Response: pc_wren=fd_wren=0, dx_flush=1, xm/mw_wren=1.
  - Exactly one bubble per hazard, because the load leaves DX on the next edge.
- MD_WAIT:
  - md_busy=1; md_cycles increments each cycle.
  - Without md_ready: pc/fd/dx_wren=0, xm_flush=1, mw_wren=1.
  - branch_taken and the load-use condition are ignored.
  - md_ready=1: all wren=1, no flush; result captured into XM; next state IDLE. md_exception rides with md_ready into ctrl bits (not this block's concern).
  - md_cycles==MD_TIMEOUT-1 and md_ready=0: md_timeout=1, same release as ready, next state IDLE.
  - md_ready wins if coincident with timeout (md_timeout=0).
- Back-to-back multdiv: a new dx_is_multdiv in IDLE immediately after release issues a fresh md_start.
- Minimum multdiv stall is 2 cycles: the start cycle plus one MD_WAIT cycle with ready.
- stall_count: +1 on each non-reset cycle with pc_wren=0; saturates at all ones and does not wrap.
- The start-cycle stall and all MD_WAIT cycles except the release cycle count as stalls.

Decomposition:
- Package pipe_ctrl_pkg: state enum {IDLE, MD_WAIT}, REG_ZERO=5'd0, NOP=32'h0.
- One sub-module, hazard_detect: the combinational load-use comparator (fd_rs, fd_rt, use bits, dx_is_load, dx_rd → load_use).

Test Plan:
- Load-use: dx_is_load=1, dx_rd=5, fd_rs=5, fd_uses_rs=1 → one cycle of pc_wren=fd_wren=0, dx_flush=1; stall_count 0→1. Same stimulus with dx_rd=0 → no stall.
- Branch + load-use in the same cycle: fd_flush=dx_flush=1, pc_wren=1, stall_count unchanged.
- Multdiv: dx_is_multdiv=1, md_ready after 3 MD_WAIT cycles → md_start pulse once, md_busy high 3 cycles, xm_flush high 3 cycles (start + 2 MD_WAIT), release cycle all wren=1, stall_count +3.
- Timeout: MD_TIMEOUT=4, md_ready never → md_timeout pulse on the 4th MD_WAIT cycle, then IDLE. Repeat with md_ready in that same cycle → md_timeout=0.
- Reset mid-MD_WAIT: reset=0 one edge → state IDLE, stall_count=0, all wren=1 during reset, no md_start afterwards unless dx_is_multdiv.
- Saturation: CNT_W=4, 20 load-use stalls → stall_count holds 15.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state type and constants for the pipeline stall/flush controller
package pipe_ctrl_pkg;
  typedef enum logic {IDLE, MD_WAIT} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [31:0] NOP = 32'h0;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs, multdiv handshake and latch controls of the pipeline controller
interface pipeline_ctrl_if #(parameter int CNT_W = 16);
  import pipe_ctrl_pkg::*;
  logic [4:0] fd_rs, fd_rt, dx_rd;
  logic fd_uses_rs, fd_uses_rt, dx_is_load, dx_is_multdiv, branch_taken;
  logic md_ready, md_exception, md_start, md_busy, md_timeout;
  logic pc_wren, fd_wren, dx_wren, xm_wren, mw_wren;
  logic fd_flush, dx_flush, xm_flush;
  logic [CNT_W-1:0] stall_count;
  modport master (
    input fd_rs, fd_rt, dx_rd, fd_uses_rs, fd_uses_rt, dx_is_load, dx_is_multdiv, branch_taken,
    input md_ready, md_exception,
    output md_start, md_busy, md_timeout, pc_wren, fd_wren, dx_wren, xm_wren, mw_wren,
    output fd_flush, dx_flush, xm_flush, stall_count
  );
  modport slave (
    output fd_rs, fd_rt, dx_rd, fd_uses_rs, fd_uses_rt, dx_is_load, dx_is_multdiv, branch_taken,
    output md_ready, md_exception,
    input md_start, md_busy, md_timeout, pc_wren, fd_wren, dx_wren, xm_wren, mw_wren,
    input fd_flush, dx_flush, xm_flush, stall_count
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: load-use comparator between the FD reader and a load sitting in DX
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] fd_rs,
  input  logic [4:0] fd_rt,
  input  logic [4:0] dx_rd,
  input  logic       fd_uses_rs,
  input  logic       fd_uses_rt,
  input  logic       dx_is_load,
  output logic       load_use
);
  assign load_use = dx_is_load && dx_rd != REG_ZERO &&
                    ((fd_uses_rs && fd_rs == dx_rd) || (fd_uses_rt && fd_rt == dx_rd));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for load-use, taken branch and multdiv occupancy of execute
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input logic            clock,
  input logic            reset,
  pipeline_ctrl_if.master bus
);
  localparam int MW = $clog2(MD_TIMEOUT);
  state_t state, next;
  logic [MW-1:0] md_cycles;
  logic [CNT_W-1:0] count;
  logic load_use, last, rel, idle, md, hold, lu, br;
  hazard_detect u_hazard (
    .fd_rs(bus.fd_rs), .fd_rt(bus.fd_rt), .dx_rd(bus.dx_rd),
    .fd_uses_rs(bus.fd_uses_rs), .fd_uses_rt(bus.fd_uses_rt),
    .dx_is_load(bus.dx_is_load), .load_use(load_use)
  );
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      md_cycles <= '0;
      count     <= '0;
    end else begin
      state     <= next;
      md_cycles <= state == IDLE ? '0 : md_cycles + MW'(1);
      if (!bus.pc_wren && ~&count) count <= count + CNT_W'(1);
    end
  end
  assign last = md_cycles == MW'(MD_TIMEOUT - 1);
  assign rel  = bus.md_ready || last;
  always_comb next = state == IDLE ? (bus.dx_is_multdiv ? MD_WAIT : IDLE) : (rel ? IDLE : MD_WAIT);
  // hold freezes PC/FD/DX and bubbles XM while execute is owned by multdiv
  always_comb begin
    idle           = state == IDLE;
    md             = idle && bus.dx_is_multdiv;
    hold           = md || (!idle && !rel);
    br             = idle && !bus.dx_is_multdiv && bus.branch_taken;
    lu             = idle && !bus.dx_is_multdiv && !bus.branch_taken && load_use;
    bus.md_start   = reset && md;
    bus.md_busy    = reset && !idle;
    bus.md_timeout = reset && !idle && last && !bus.md_ready;
    bus.pc_wren    = !reset || !(hold || lu);
    bus.fd_wren    = !reset || !(hold || lu);
    bus.dx_wren    = !reset || !hold;
    bus.xm_wren    = 1'b1;
    bus.mw_wren    = 1'b1;
    bus.fd_flush   = reset && br;
    bus.dx_flush   = reset && (br || lu);
    bus.xm_flush   = reset && hold;
  end
  assign bus.stall_count = count;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench; a cycle-level reference model predicts every control output
module tb_pipeline_ctrl;
  localparam int TO = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  typedef struct {
    logic [10:0] ctl;
    int          cnt;
    bit          cnt_ok;
  } exp_t;
  logic clock = 0, reset = 0;
  pipeline_ctrl_if #(.CNT_W(CW)) bus();
  pipeline_ctrl #(.MD_TIMEOUT(TO), .CNT_W(CW)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  exp_t q[$];
  int errors = 0, checks = 0;
  bit m_busy = 0, m_cnt_ok = 0;
  int m_waited = 0, m_cnt = 0;
  task automatic drive(input bit rn, mult, br, ld, input logic [4:0] rd, rs, rt,
                       input bit urs, urt, ready);
    bit st, bz, to, pcw, dxw, fdf, dxf, xmf, hz;
    exp_t e;
    reset = rn; bus.dx_is_multdiv = mult; bus.branch_taken = br; bus.dx_is_load = ld;
    bus.dx_rd = rd; bus.fd_rs = rs; bus.fd_rt = rt; bus.fd_uses_rs = urs; bus.fd_uses_rt = urt;
    bus.md_ready = ready; bus.md_exception = ready & $urandom_range(0, 1);
    st = 0; bz = 0; to = 0; pcw = 1; dxw = 1; fdf = 0; dxf = 0; xmf = 0;
    hz = ld && rd != 0 && ((urs && rs == rd) || (urt && rt == rd));
    e.cnt = m_cnt; e.cnt_ok = m_cnt_ok;
    if (!rn) begin
      m_busy = 0; m_waited = 0;
    end else if (!m_busy) begin
      if (mult) begin st = 1; pcw = 0; dxw = 0; xmf = 1; m_busy = 1; m_waited = 0; end
      else if (br) begin fdf = 1; dxf = 1; end
      else if (hz) begin pcw = 0; dxf = 1; end
    end else begin
      m_waited++; bz = 1;
      if (ready || m_waited == TO) begin to = !ready; m_busy = 0; end
      else begin pcw = 0; dxw = 0; xmf = 1; end
    end
    e.ctl = {st, bz, to, pcw, pcw, dxw, 1'b1, 1'b1, fdf, dxf, xmf};
    q.push_back(e);
    if (!rn) begin m_cnt = 0; m_cnt_ok = 1; end
    else if (!pcw && m_cnt < CMAX) m_cnt++;
    @(posedge clock); #1;
  endtask
  task automatic idle_cycle(input bit ready);
    drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, ready);
  endtask
  always @(negedge clock) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [10:0] got;
      e = q.pop_front();
      got = {bus.md_start, bus.md_busy, bus.md_timeout, bus.pc_wren, bus.fd_wren, bus.dx_wren,
             bus.xm_wren, bus.mw_wren, bus.fd_flush, bus.dx_flush, bus.xm_flush};
      checks++;
      if (got !== e.ctl) begin
        errors++;
        $display("FAIL ctl @%0t: got %b want %b (start busy to pc fd dx xm mw fdf dxf xmf)", $time, got, e.ctl);
      end
      if (e.cnt_ok) begin
        checks++;
        if (int'(bus.stall_count) != e.cnt || $isunknown(bus.stall_count)) begin
          errors++;
          $display("FAIL stall_count @%0t: got %0d want %0d", $time, bus.stall_count, e.cnt);
        end
      end
    end
  end
  initial begin
    reset = 0;
    @(posedge clock); #1;
    drive(0, 1, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1);
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    drive(1, 0, 0, 1, 5'd5, 5'd5, 5'd1, 1, 0, 0);
    idle_cycle(0);
    drive(1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0);
    drive(1, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 1, 0);
    drive(1, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0);
    drive(1, 0, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0);
    idle_cycle(0);
    drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    drive(1, 1, 1, 1, 5'd3, 5'd3, 5'd3, 1, 1, 0);
    idle_cycle(0);
    drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    idle_cycle(1);
    idle_cycle(0);
    drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    repeat (TO) idle_cycle(0);
    idle_cycle(0);
    drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    repeat (TO - 1) idle_cycle(0);
    idle_cycle(1);
    drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    idle_cycle(0);
    drive(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    idle_cycle(0);
    idle_cycle(0);
    repeat (20) drive(1, 0, 0, 1, 5'd9, 5'd9, 5'd0, 1, 0, 0);
    idle_cycle(0);
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    repeat (400) begin
      drive($urandom_range(0, 39) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) == 0);
    end
    @(negedge clock); #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
